count_sampler: RTL
==================

# count_sampler

Downstream consumer of the 5-bit `counter` output. It samples `count` every clock, checks that it advances by exactly one (mod 2^WIDTH), and records wrap, skip and stall events in a small FIFO. The Ruby-VPI bench drains that FIFO through a valid/ready port, so the bench reads the counter's history as discrete events instead of polling `count` every edge.

## Interface
- WIDTH, 5, width of the monitored count
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- WRAP_W, 8, width of saturating wrap counter
- STALL_LIM, 8, consecutive unchanged samples that raise a STALL event
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- count  in  WIDTH  counter value under observation
- enable  in  1  sampling enable
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_data  out  WIDTH+2  {kind[1:0], value[WIDTH-1:0]}
- wrap_count  out  WRAP_W  number of wraps seen, saturates at all-ones
- overflow  out  1  sticky: an event was dropped because FIFO was full

## Operation
- Reset (rst_n low at a rising edge): state IDLE, FIFO empty, evt_valid=0, evt_data=0, wrap_count=0, overflow=0, hold-run counter=0.
- States: IDLE, PRIME, TRACK.
  - IDLE: enable=1 → PRIME.
  - PRIME: latch count into prev, clear hold-run → TRACK. No comparison, no event.
  - TRACK: compare count against prev, then update prev.
  - enable=0 in any state → IDLE next cycle. The current cycle's sample is discarded, with no comparison and no event.
- TRACK classification, with exp = prev+1 truncated to WIDTH:
  - count==exp and count==0: WRAP event {2'b01, count}; wrap_count += 1 unless saturated.
  - count==exp, nonzero: no event; hold-run cleared.
  - count==prev: hold-run += 1. STALL event {2'b11, count} fires exactly once, on the sample where hold-run reaches STALL_LIM. Hold-run saturates there and clears on any change.
  - Otherwise: SKIP event {2'b10, count}; hold-run cleared.
- Kind 2'b00 is never produced.
- FIFO: push when an event is generated and the FIFO is not full, or is full and popping this cycle. An event arriving when the FIFO is full with no pop is dropped and sets overflow (sticky until reset).
- Pop when evt_valid && evt_ready. The FIFO has no bypass.

## Timing
- Event latency: the event is generated at edge N (sample of count before edge N) and is visible on evt_valid/evt_data after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle, so a full FIFO with simultaneous push and pop stays full and nothing is lost.
- evt_data is stable while evt_valid=1 and evt_ready=0.
- Reset mid-operation: FIFO contents are lost. The first event after reset needs ≥3 edges (IDLE→PRIME→TRACK).
- enable toggling low for one cycle forces re-PRIME; the discontinuity across the gap is never reported as SKIP.

## Configuration
- COUNT_SAMPLER_STALL_EN defined: hold-run counter and STALL events are present as described.
- Undefined: hold-run logic is removed, STALL_LIM is ignored, and unchanged samples produce no event. Kind 2'b11 never appears.

## Structure
- Package count_sampler_pkg:
  - state enum {IDLE, PRIME, TRACK}
  - kind constants KIND_WRAP=2'b01, KIND_SKIP=2'b10, KIND_STALL=2'b11
  - event record typedef parameterised on WIDTH via a localparam default of 5
- Sub-module event_fifo:
  - synchronous FIFO with DEPTH entries, registered outputs, full/empty, and push/pop on the same cycle.
  - count_sampler holds the classifier FSM, prev register, wrap and hold-run counters, and the overflow flag.

## Test plan
- Free-running counter, enable=1, evt_ready=1, 70 cycles → exactly two events, {01,0} each, 32 cycles apart; wrap_count=2; overflow=0.
- Force count sequence 3,4,9,10 in TRACK → one event {10,9}; no event for 4 or 10.
- Hold count at 7 for 10 samples (macro defined) → one {11,7} on the 8th repeat only. Same stimulus with the macro undefined → no events.
- evt_ready=0, inject 5 SKIPs with DEPTH=4 → first 4 queued in order; 5th dropped; overflow=1 and stays 1 after draining.
- FIFO full, then a SKIP arrives in the same cycle as evt_ready=1 → head popped, new event stored, overflow stays 0.
- Deassert rst_n for one edge while evt_valid=1 → next cycle evt_valid=0, wrap_count=0, overflow=0; no event until after the PRIME cycle.

Source files
------------

// File: rtl/count_sampler_pkg.sv
// Shared types for the count_sampler block: classifier states, event kinds
// and the packed event record {kind, value}.
// Ports: none (package).
package count_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Kind 2'b00 is reserved and never emitted, so a zero word never looks
  // like a real event.
  localparam logic [1:0] KIND_WRAP  = 2'b01;
  localparam logic [1:0] KIND_SKIP  = 2'b10;
  localparam logic [1:0] KIND_STALL = 2'b11;

  localparam int EVT_VALUE_W = 5;

  typedef struct packed {
    logic [1:0]             kind;
    logic [EVT_VALUE_W-1:0] value;
  } evt_t;

  function automatic evt_t mk_evt(input logic [1:0] kind,
                                  input logic [EVT_VALUE_W-1:0] value);
    evt_t e;
    e.kind  = kind;
    e.value = value;
    return e;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO for sampler events, DEPTH entries (power of two, >= 2).
// Ports: clk_i/rst_n_i (sync active-low), push_i/din_i write side,
//        pop_i/dout_o read side, full_o/empty_o status. No bypass path.
module event_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Head is driven purely from flops; forced to zero when empty so the
  // output reads 0 out of reset and between events.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/count_sampler.sv
// Monitors a free-running counter, checks it advances by one each sample and
// queues WRAP/SKIP/STALL events; consumer drains them via evt_valid/evt_ready.
// Ports: clk, rst_n (sync active-low), count/enable in, evt_* out port,
//        wrap_count (saturating), overflow (sticky event-drop flag).
// Optional: COUNT_SAMPLER_STALL_EN adds the hold-run counter and STALL events.
module count_sampler
  import count_sampler_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int STALL_LIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count,
  input  logic              enable,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [WIDTH+1:0]  evt_data,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              overflow
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  exp_val;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              ovf_q, ovf_d;

  logic              evt_gen;
  logic [1:0]        evt_kind;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

`ifdef COUNT_SAMPLER_STALL_EN
  localparam int              HOLD_W   = $clog2(STALL_LIM + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(STALL_LIM);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  assign hold_inc = hold_q + HOLD_W'(1);
`endif

  assign exp_val = prev_q + WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    wrap_d   = wrap_q;
    evt_gen  = 1'b0;
    evt_kind = KIND_SKIP;
`ifdef COUNT_SAMPLER_STALL_EN
    hold_d   = hold_q;
`endif
    // Dropping enable discards this sample and forces a fresh PRIME, so a
    // gap in the count is never mistaken for a skip.
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: begin
          prev_d  = count;
`ifdef COUNT_SAMPLER_STALL_EN
          hold_d  = '0;
`endif
          state_d = TRACK;
        end
        TRACK: begin
          prev_d = count;
          if (count == exp_val) begin
`ifdef COUNT_SAMPLER_STALL_EN
            hold_d = '0;
`endif
            if (count == '0) begin
              evt_gen  = 1'b1;
              evt_kind = KIND_WRAP;
              if (wrap_q != '1) wrap_d = wrap_q + WRAP_W'(1);
            end
          end else if (count == prev_q) begin
`ifdef COUNT_SAMPLER_STALL_EN
            // Saturate at the limit so the STALL fires once per run.
            if (hold_q != HOLD_LIM) begin
              hold_d = hold_inc;
              if (hold_inc == HOLD_LIM) begin
                evt_gen  = 1'b1;
                evt_kind = KIND_STALL;
              end
            end
`endif
          end else begin
`ifdef COUNT_SAMPLER_STALL_EN
            hold_d   = '0;
`endif
            evt_gen  = 1'b1;
            evt_kind = KIND_SKIP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts an event when its head leaves this cycle.
  assign pop   = evt_valid && evt_ready;
  assign push  = evt_gen && (!fifo_full || pop);
  assign ovf_d = ovf_q || (evt_gen && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      wrap_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef COUNT_SAMPLER_STALL_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
`ifdef COUNT_SAMPLER_STALL_EN
      hold_q  <= hold_d;
`endif
    end
  end

  event_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .push_i  (push),
    .din_i   ({evt_kind, count}),
    .pop_i   (pop),
    .dout_o  (evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign wrap_count = wrap_q;
  assign overflow   = ovf_q;

endmodule
